uart_mmio: RTL

- Memory-mapped 8N1 UART peripheral on the byte-wide bus driven by the 16-bit CPU core.
- Decodes an 8-byte window of the core's 16-bit address space.
- Accepts core byte writes (core `we` / `out`) and returns read data on the same cycle the address is presented.
- The system bus mux selects `rdata` onto the core's `in` whenever `hit`=1.

---
 rtl/uart_mmio_pkg.sv | 25 ++
 rtl/uart_mmio_if.sv | 11 +
 rtl/uart_mmio_byte_fifo.sv | 49 ++++
 rtl/uart_mmio.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - register offsets, STATUS bit indices and serial state enum for uart_mmio
package uart_mmio_pkg;

    localparam logic [2:0] OFS_DATA   = 3'd0;
    localparam logic [2:0] OFS_STATUS = 3'd1;
    localparam logic [2:0] OFS_DIVLO  = 3'd2;
    localparam logic [2:0] OFS_DIVHI  = 3'd3;
    localparam logic [2:0] OFS_RXPOP  = 3'd4;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_TX_BUSY     = 2;
    localparam int ST_RX_VALID    = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_TX_OVERFLOW = 5;
    localparam int ST_FRAME_ERR   = 6;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} serial_state_e;

    // A zero divider still yields a one-clock bit.
    function automatic logic [15:0] bit_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// rtl/uart_mmio_if.sv - byte-wide core bus into the uart_mmio window
interface uart_mmio_if;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic        we;
    logic        hit;
    logic [7:0]  rdata;

    modport master (output address, wdata, we, input hit, rdata);
    modport slave  (input address, wdata, we, output hit, rdata);
endinterface

// File: rtl/uart_mmio_byte_fifo.sv
// rtl/uart_mmio_byte_fifo.sv - byte FIFO with full/empty flags and combinational head
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CNT_MAX);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd];
    // A push into a full FIFO is dropped even if a pop happens the same cycle.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_ONE;
            if (w_pop)  r_rd <= r_rd + PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
        end
    end
endmodule

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped 8N1 UART; receiver present only when UART_MMIO_RX_EN is defined
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'hFFF0,
    parameter logic [15:0] DIV_DEFAULT = 16'd434,
    parameter int          TX_DEPTH    = 4,
    parameter int          RX_DEPTH    = 4
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    uart_mmio_if.slave bus,
    input  logic       i_rxd,
    output logic       o_txd,
    output logic       o_irq
);
    logic [2:0]    w_ofs;
    logic          w_wr, w_stat_wr;
    logic [15:0]   r_div;
    logic          r_tx_overflow, r_rx_overrun, r_frame_err, r_irq;
    logic          w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_busy, w_tx_boundary;
    logic [7:0]    w_tx_head, w_status;
    serial_state_e r_tx_state;
    logic [15:0]   r_tx_cnt, r_tx_period;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_txd;
    logic          w_rx_valid, w_rx_full, w_rx_done_ok, w_rx_ferr, w_rx_pop;
    logic [7:0]    w_rx_head;

    assign w_ofs     = bus.address[2:0];
    assign bus.hit   = (bus.address[15:3] == BASE[15:3]);
    assign w_wr      = bus.we & bus.hit;
    assign w_stat_wr = w_wr & (w_ofs == OFS_STATUS);
    assign w_tx_push = w_wr & (w_ofs == OFS_DATA);
    assign w_rx_pop  = w_wr & (w_ofs == OFS_RXPOP);
    assign o_txd     = r_txd;
    assign o_irq     = r_irq;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .i_push(w_tx_push), .i_data(bus.wdata), .i_pop(w_tx_pop),
        .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
    );

    assign w_tx_busy     = (r_tx_state != S_IDLE);
    assign w_tx_boundary = (r_tx_cnt == r_tx_period - 16'd1);
    // The FIFO is drained from IDLE or straight out of STOP so queued frames abut.
    assign w_tx_pop = ~w_tx_empty &
                      ((r_tx_state == S_IDLE) | ((r_tx_state == S_STOP) & w_tx_boundary));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tx_state  <= S_IDLE;
            r_txd       <= 1'b1;
            r_tx_shift  <= 8'h00;
            r_tx_cnt    <= 16'd0;
            r_tx_period <= 16'd1;
            r_tx_bit    <= 3'd0;
        end else if (r_tx_state == S_IDLE) begin
            if (w_tx_pop) begin
                r_tx_state  <= S_START;
                r_txd       <= 1'b0;
                r_tx_shift  <= w_tx_head;
                r_tx_cnt    <= 16'd0;
                r_tx_period <= bit_period(r_div);
            end
        end else if (!w_tx_boundary) begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
        end else begin
            r_tx_cnt    <= 16'd0;
            r_tx_period <= bit_period(r_div);
            case (r_tx_state)
                S_START: begin
                    r_tx_state <= S_DATA;
                    r_txd      <= r_tx_shift[0];
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx_bit   <= 3'd0;
                end
                S_DATA: begin
                    if (r_tx_bit == 3'd7) begin
                        r_tx_state <= S_STOP;
                        r_txd      <= 1'b1;
                    end else begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit   <= r_tx_bit + 3'd1;
                    end
                end
                default: begin
                    if (w_tx_pop) begin
                        r_tx_state <= S_START;
                        r_txd      <= 1'b0;
                        r_tx_shift <= w_tx_head;
                    end else begin
                        r_tx_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef UART_MMIO_RX_EN
    logic [2:0]    r_rx_sync;
    serial_state_e r_rx_state;
    logic [15:0]   r_rx_cnt, r_rx_period, w_rx_half;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          r_rx_done_ok, r_rx_ferr, w_rxs, w_rx_fall, w_rx_empty;

    assign w_rxs        = r_rx_sync[1];
    assign w_rx_fall    = r_rx_sync[2] & ~r_rx_sync[1];
    assign w_rx_done_ok = r_rx_done_ok;
    assign w_rx_ferr    = r_rx_ferr;
    assign w_rx_valid   = ~w_rx_empty;
    // Mid-start check point, pulled in by the two clocks lost to sync and edge detect.
    assign w_rx_half = (r_rx_period >= 16'd4) ? (r_rx_period >> 1) - 16'd2 : 16'd0;

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .i_push(r_rx_done_ok), .i_data(r_rx_shift), .i_pop(w_rx_pop),
        .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_sync    <= 3'b111;
            r_rx_state   <= S_IDLE;
            r_rx_cnt     <= 16'd0;
            r_rx_period  <= 16'd1;
            r_rx_bit     <= 3'd0;
            r_rx_shift   <= 8'h00;
            r_rx_done_ok <= 1'b0;
            r_rx_ferr    <= 1'b0;
        end else begin
            r_rx_sync    <= {r_rx_sync[1:0], i_rxd};
            r_rx_done_ok <= 1'b0;
            r_rx_ferr    <= 1'b0;
            case (r_rx_state)
                S_IDLE: if (w_rx_fall) begin
                    r_rx_state  <= S_START;
                    r_rx_cnt    <= 16'd0;
                    r_rx_period <= bit_period(r_div);
                end
                S_START: if (r_rx_cnt == w_rx_half) begin
                    r_rx_cnt    <= 16'd0;
                    r_rx_period <= bit_period(r_div);
                    r_rx_bit    <= 3'd0;
                    r_rx_state  <= w_rxs ? S_IDLE : S_DATA;
                end else r_rx_cnt <= r_rx_cnt + 16'd1;
                S_DATA: if (r_rx_cnt == r_rx_period - 16'd1) begin
                    r_rx_cnt    <= 16'd0;
                    r_rx_period <= bit_period(r_div);
                    r_rx_shift  <= {w_rxs, r_rx_shift[7:1]};
                    r_rx_bit    <= r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
                end else r_rx_cnt <= r_rx_cnt + 16'd1;
                default: if (r_rx_cnt == r_rx_period - 16'd1) begin
                    r_rx_cnt     <= 16'd0;
                    r_rx_state   <= S_IDLE;
                    r_rx_done_ok <= w_rxs;
                    r_rx_ferr    <= ~w_rxs;
                end else r_rx_cnt <= r_rx_cnt + 16'd1;
            endcase
        end
    end
`else
    logic w_unused_rx;
    assign w_unused_rx  = i_rxd ^ w_rx_pop;
    assign w_rx_valid   = 1'b0;
    assign w_rx_full    = 1'b0;
    assign w_rx_done_ok = 1'b0;
    assign w_rx_ferr    = 1'b0;
    assign w_rx_head    = 8'h00;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div         <= DIV_DEFAULT;
            r_tx_overflow <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_irq <= w_rx_valid | (w_tx_empty & ~w_tx_busy);
            if (w_wr && w_ofs == OFS_DIVLO) r_div[7:0]  <= bus.wdata;
            if (w_wr && w_ofs == OFS_DIVHI) r_div[15:8] <= bus.wdata;
            if (w_tx_push && w_tx_full) r_tx_overflow <= 1'b1;
            else if (w_stat_wr && bus.wdata[ST_TX_OVERFLOW]) r_tx_overflow <= 1'b0;
            if (w_rx_done_ok && w_rx_full) r_rx_overrun <= 1'b1;
            else if (w_stat_wr && bus.wdata[ST_RX_OVERRUN]) r_rx_overrun <= 1'b0;
            if (w_rx_ferr) r_frame_err <= 1'b1;
            else if (w_stat_wr && bus.wdata[ST_FRAME_ERR]) r_frame_err <= 1'b0;
        end
    end

    always_comb begin
        w_status                 = 8'h00;
        w_status[ST_TX_FULL]     = w_tx_full;
        w_status[ST_TX_EMPTY]    = w_tx_empty;
        w_status[ST_TX_BUSY]     = w_tx_busy;
        w_status[ST_RX_VALID]    = w_rx_valid;
        w_status[ST_RX_OVERRUN]  = r_rx_overrun;
        w_status[ST_TX_OVERFLOW] = r_tx_overflow;
        w_status[ST_FRAME_ERR]   = r_frame_err;
    end

    always_comb begin
        bus.rdata = 8'h00;
        if (bus.hit) begin
            case (w_ofs)
                OFS_DATA:   bus.rdata = w_rx_valid ? w_rx_head : 8'h00;
                OFS_STATUS: bus.rdata = w_status;
                OFS_DIVLO:  bus.rdata = r_div[7:0];
                OFS_DIVHI:  bus.rdata = r_div[15:8];
                default:    bus.rdata = 8'h00;
            endcase
        end
    end
endmodule
